shared_reg_arbiter: RTL and testbench

Round-robin arbiter that shares a single pipeline holding register among N requesters. Each requester offers a WIDTH-bit word with a valid/ready handshake. The winner's word is captured into the shared register and presented downstream with the winner's index, also under valid/ready. The block sits between multiple producers (e.g. fetch/LSU/PTW request sources) and one consumer stage, replacing a bare per-stage flop wherever that register must be time-shared.

---
 rtl/shared_reg_arbiter.sv | 99 +++++++++
 tb/tb_shared_reg_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that time-shares one holding register among N requesters.
// The winner's word and index are registered and drained under valid/ready.
module shared_reg_arbiter #(
   parameter  int N     = 4,
   parameter  int WIDTH = 64,
   localparam int IDXW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N-1:0]         req_valid,
   input  logic [N*WIDTH-1:0]   req_data,
   output logic [N-1:0]         req_ready,
   input  logic                 flush,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [IDXW-1:0]      out_src,
   input  logic                 out_ready
);

   localparam logic [N-1:0]    LANE0    = N'(1);
   localparam logic [IDXW:0]   N_WIDE   = (IDXW+1)'(N);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   logic                 valid_q, valid_d;
   logic [WIDTH-1:0]     data_q,  data_d;
   logic [IDXW-1:0]      src_q,   src_d;
   logic [IDXW-1:0]      ptr_q,   ptr_d;

   logic [WIDTH-1:0]     req_word [N];
   logic [IDXW-1:0]      cand_idx [N];
   logic [N-1:0]         cand_hit;
   logic [IDXW-1:0]      win_idx;
   logic                 any_req;
   logic                 load_en;
   logic                 grant;

   // Offset gi from the pointer names the requester checked at priority gi.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [IDXW:0] sum;

      assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
      assign sum          = {1'b0, ptr_q} + (IDXW+1)'(gi);
      assign cand_idx[gi] = (sum >= N_WIDE) ? IDXW'(sum - N_WIDE) : sum[IDXW-1:0];
      assign cand_hit[gi] = req_valid[cand_idx[gi]];
   end

   always_comb begin
      win_idx = '0;
      any_req = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (cand_hit[k]) begin
            win_idx = cand_idx[k];
            any_req = 1'b1;
         end
      end
   end

   assign load_en = !flush && (!valid_q || out_ready);
   assign grant   = load_en && any_req;

   assign req_ready = (grant && reset_n) ? (LANE0 << win_idx) : '0;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      src_d   = src_q;
      ptr_d   = ptr_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (grant) begin
         valid_d = 1'b1;
         data_d  = req_word[win_idx];
         src_d   = win_idx;
         ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + IDXW'(1);
      end else if (load_en) begin
         // Drained (or already empty) with nothing to refill.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_src   = src_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios then random traffic,
// with a queue-based scoreboard fed by a behavioural round-robin model.
module tb_shared_reg_arbiter;

   localparam int N     = 4;
   localparam int WIDTH = 64;
   localparam int IDXW  = $clog2(N);

   typedef struct {
      int               src;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [N-1:0]         req_valid = '0;
   logic [N*WIDTH-1:0]   req_data = '0;
   logic [N-1:0]         req_ready;
   logic                 flush = 1'b0;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [IDXW-1:0]      out_src;
   logic                 out_ready = 1'b0;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   bit   started = 1'b0;
   bit   rst_chk = 1'b0;
   int   m_ptr   = 0;
   bit   m_valid = 1'b0;

   shared_reg_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [N*WIDTH-1:0] rand_data();
      logic [N*WIDTH-1:0] d;
      for (int i = 0; i < N; i++) d[i*WIDTH +: WIDTH] = {$urandom, $urandom};
      return d;
   endfunction

   // One clock cycle: drive inputs, check req_ready, advance the model.
   task automatic cycle(input logic [N-1:0] rv, input logic [N*WIDTH-1:0] d,
                        input logic fl, input logic ordy, input logic rst);
      logic [N-1:0] exp_rdy;
      int           w;
      @(negedge clk);
      if (rst_chk) begin
         total++;
         if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%0b data=%0h src=%0d, need 0/0/0",
                     out_valid, out_data, out_src);
         end
         rst_chk = 1'b0;
         started = 1'b1;
      end
      req_valid = rv; req_data = d; flush = fl; out_ready = ordy; reset_n = rst;
      #1;
      w = -1;
      for (int k = 0; k < N; k++) begin
         if (w < 0 && rv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      exp_rdy = '0;
      if (rst && !fl && (!m_valid || ordy) && w >= 0) exp_rdy[w] = 1'b1;
      total++;
      if (req_ready !== exp_rdy) begin
         bad++;
         $display("FAIL req_ready: got %b, need %b (req_valid=%b ptr=%0d)",
                  req_ready, exp_rdy, rv, m_ptr);
      end
      $display("cycle rst_n=%0b flush=%0b out_ready=%0b req_valid=%b req_ready=%b",
               rst, fl, ordy, rv, req_ready);
      if (!rst) begin
         exp_q.delete();
         m_valid = 1'b0;
         m_ptr   = 0;
         rst_chk = 1'b1;
      end else if (fl) begin
         if (m_valid) void'(exp_q.pop_front());
         m_valid = 1'b0;
      end else if (!m_valid || ordy) begin
         if (w >= 0) begin
            exp_q.push_back('{src: w, data: d[w*WIDTH +: WIDTH]});
            m_valid = 1'b1;
            m_ptr   = (w + 1) % N;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   // Monitor: out_valid after each edge must match whether a word is pending.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (started) begin
            total++;
            if (out_valid !== (exp_q.size() != 0)) begin
               bad++;
               $display("FAIL out_valid: got %b, need %b", out_valid, exp_q.size() != 0);
            end
         end
      end
   end

   // Monitor: every accepted word is popped from the scoreboard and compared.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (started && reset_n && !flush && out_valid === 1'b1 && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL out_word: got src=%0d data=%0h, need no word", out_src, out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_src !== IDXW'(e.src) || out_data !== e.data) begin
                  bad++;
                  $display("FAIL out_word: got src=%0d data=%0h, need src=%0d data=%0h",
                           out_src, out_data, e.src, e.data);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, need finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N*WIDTH-1:0] d;
      // Reset, then a single request from requester 0.
      cycle('0, '0, 1'b0, 1'b0, 1'b0);
      cycle('0, '0, 1'b0, 1'b0, 1'b0);
      d = rand_data(); d[WIDTH-1:0] = 64'hA5;
      cycle(4'b0001, d, 1'b0, 1'b0, 1'b1);
      cycle(4'b0000, rand_data(), 1'b0, 1'b1, 1'b1);
      // Rotation with everyone requesting and the consumer always ready.
      for (int i = 0; i < 8; i++) cycle(4'b1111, rand_data(), 1'b0, 1'b1, 1'b1);
      cycle(4'b0000, rand_data(), 1'b0, 1'b1, 1'b1);
      // Backpressure on a held 0x11 word.
      d = rand_data(); d[WIDTH-1:0] = 64'h11;
      cycle(4'b0001, d, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(4'b0110, rand_data(), 1'b0, 1'b0, 1'b1);
      cycle(4'b0110, rand_data(), 1'b0, 1'b1, 1'b1);
      // Drain with no request.
      cycle(4'b0000, rand_data(), 1'b0, 1'b1, 1'b1);
      // Flush while full, then resume from the pointer.
      cycle(4'b0001, rand_data(), 1'b0, 1'b1, 1'b1);
      cycle(4'b1111, rand_data(), 1'b1, 1'b1, 1'b1);
      cycle(4'b1111, rand_data(), 1'b0, 1'b1, 1'b1);
      // Reset mid-operation, then requester 0 must win over 3.
      cycle(4'b0100, rand_data(), 1'b0, 1'b1, 1'b1);
      cycle(4'b1001, rand_data(), 1'b0, 1'b0, 1'b0);
      cycle(4'b1001, rand_data(), 1'b0, 1'b1, 1'b1);
      cycle(4'b1001, rand_data(), 1'b0, 1'b1, 1'b1);
      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         cycle(N'($urandom), rand_data(), ($urandom % 8) == 0,
               ($urandom % 4) != 0, ($urandom % 100) != 0);
      end
      cycle('0, '0, 1'b0, 1'b1, 1'b1);
      cycle('0, '0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_end: got %0d pending words, need 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
